uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and width/divider helpers for the UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Guarded so an illegal divider still elaborates far enough to hit the DIV check.
  function automatic int ctr_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - byte FIFO with push/pop/count, head word visible combinationally
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push_i,
  input  logic [7:0]                    wr_data_i,
  input  logic                          pop_i,
  output logic [7:0]                    rd_data_o,
  output logic [count_width(DEPTH)-1:0] count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with registered serial output
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [7:0]                         in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               uart_txd,
  output logic                               busy,
  output logic [count_width(FIFO_DEPTH)-1:0] fifo_count
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int BW  = ctr_width(DIV);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  tx_state_e     state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          rdy_q;
  logic          tick, push, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;

  sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push_i   (push),
    .wr_data_i(in_data),
    .pop_i    (pop),
    .rd_data_o(fifo_head),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // rdy_q keeps in_ready low through reset and for the release edge itself.
  assign in_ready = rdy_q && !fifo_full;
  assign push     = in_valid && in_ready;
  assign tick     = (cnt_q == BW'(DIV - 1));
  assign uart_txd = txd_q;
  assign busy     = busy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = START;
        end
      end
      START: begin
        cnt_d = cnt_q + BW'(1);
        if (tick) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + BW'(1);
        if (tick) begin
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_q + BW'(1);
        if (tick) begin
          cnt_d = '0;
          // Chain straight into the next start bit so frames abut.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line trails the state by one cycle; busy covers that trailing stop cycle.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[bit_idx_q];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE) || (state_d != IDLE) || !fifo_empty || push;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      rdy_q     <= 1'b1;
    end
  end

endmodule
